// File: rtl/shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter
//
// Round-robin arbiter that lets NUM_REQ producers share a single registered
// WIDTH-bit output stage. Each accepted beat is stored in the output register
// together with the index of the requester that sent it. The output stage
// drains and reloads in the same cycle, so it can carry one beat per cycle.
//
// Optional feature (compile-time macro SHARED_REG_ARB_LOCK_EN):
//   This adds the req_lock port and a two-state OPEN/LOCKED FSM. While LOCKED,
//   one requester keeps ownership for up to DEPTH consecutive beats. Without
//   the macro, the arbiter is pure round robin and the FSM and counter do not
//   exist.
//
// Parameters:
//   NUM_REQ  number of requesters (2..16)
//   WIDTH    data width per beat
//   DEPTH    maximum consecutive beats under lock (2..256)
//   IDW      width of the requester index
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester beat valid
//   req_data   packed beats, requester i at [i*WIDTH +: WIDTH]
//   req_lock   per-requester burst-lock request (only with the macro)
//   req_ready  one-hot (or zero) grant; a beat moves on req_valid & req_ready
//   out_valid  the output register holds a beat
//   out_ready  downstream accepts the held beat
//   out_data   registered beat
//   out_id     index of the requester that produced out_data
// ---------------------------------------------------------------------------
module shared_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
`ifdef SHARED_REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock,
`endif
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [IDW-1:0]           out_id
);

  // Stop elaboration if a parameter is outside its legal range.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("shared_reg_arbiter: NUM_REQ out of range");
  end
  if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
    $error("shared_reg_arbiter: DEPTH out of range");
  end

  // Returns the index after k, wrapping from NUM_REQ-1 to 0. NUM_REQ does not
  // have to be a power of two.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] k);
    return (k == IDW'(NUM_REQ - 1)) ? '0 : k + 1'b1;
  endfunction

  logic [IDW-1:0] ptr;
  logic           load_ok;
  logic           rr_found;
  logic [IDW-1:0] rr_idx;
  int             scan_idx;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic           xfer;

  assign load_ok = !out_valid || out_ready;

  // Round-robin search. It starts at ptr and goes upward with wrap-around.
  // The first asserted req_valid wins.
  // NOTE: every variable this block writes gets a default first, so no path
  // can leave a value unassigned and infer a latch.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr;
    scan_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = int'(ptr) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!rr_found && req_valid[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = IDW'(scan_idx);
      end
    end
  end

`ifdef SHARED_REG_ARB_LOCK_EN
  localparam int CNTW = $clog2(DEPTH + 1);

  localparam logic STATE_OPEN   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  logic            state;
  logic [IDW-1:0]  owner;
  logic [CNTW-1:0] cnt;
  logic            abandon;

  // While LOCKED, only the owner can win. The value of ptr does not matter.
  always_comb begin
    if (state == STATE_LOCKED) begin
      win_found = req_valid[owner];
      win_idx   = owner;
    end else begin
      win_found = rr_found;
      win_idx   = rr_idx;
    end
  end

  // If the owner drops its valid while the stage could have loaded, the owner
  // has given up the lock.
  assign abandon = (state == STATE_LOCKED) && load_ok && !req_valid[owner];
`else
  assign win_found = rr_found;
  assign win_idx   = rr_idx;
`endif

  // req_ready is forced low while reset is held, even though the output
  // stage looks empty and could load.
  assign xfer = rst_n && load_ok && win_found;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win_idx] = 1'b1;
  end

  // Output register. It loads on a transfer, empties when drained without a
  // refill, and otherwise holds its value.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= req_data[win_idx*WIDTH +: WIDTH];
      out_id    <= win_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SHARED_REG_ARB_LOCK_EN
  // Round-robin pointer plus the lock FSM. An abandoned lock also moves the
  // pointer past the owner, so the owner does not win again right away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      state <= STATE_OPEN;
      owner <= '0;
      cnt   <= '0;
    end else begin
      if (xfer) ptr <= next_idx(win_idx);
      case (state)
        STATE_OPEN: begin
          if (xfer && req_lock[win_idx]) begin
            state <= STATE_LOCKED;
            owner <= win_idx;
            cnt   <= CNTW'(1);
          end
        end
        default: begin
          if (xfer) begin
            if (!req_lock[owner] || (cnt + CNTW'(1) == CNTW'(DEPTH))) begin
              state <= STATE_OPEN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end else if (abandon) begin
            state <= STATE_OPEN;
            cnt   <= '0;
            ptr   <= next_idx(owner);
          end
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= next_idx(win_idx);
    end
  end
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_reg_arbiter
//
// Directed testbench for shared_reg_arbiter with NUM_REQ=4, WIDTH=8 and
// DEPTH=16. Inputs change just after each falling edge. Outputs are checked
// 1 ns later, well away from the rising edge. Every expected value is worked
// out by hand from the round-robin and lock rules. The burst-lock scenarios
// run only when SHARED_REG_ARB_LOCK_EN is defined.
// ---------------------------------------------------------------------------
module tb_shared_reg_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int IDW     = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
`ifdef SHARED_REG_ARB_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock;
`endif
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [IDW-1:0]           out_id;

  logic [WIDTH-1:0] beat [NUM_REQ];

  int n_checks = 0;
  int n_errors = 0;

  assign req_data = {beat[3], beat[2], beat[1], beat[0]};

  shared_reg_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .IDW     (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef SHARED_REG_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Watchdog: the run is bounded by the clock, but this stops it if anything
  // stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b1;
`ifdef SHARED_REG_ARB_LOCK_EN
    req_lock  = 4'h0;
`endif
    for (int i = 0; i < NUM_REQ; i++) beat[i] = 8'h10 + 8'(i);

    // Reset held with every requester valid.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data",  32'(out_data),  32'h00);
    check("rst_id",    32'(out_id),    32'h0);

    // Fairness: every requester valid, so grants go 0,1,2,3,0,1,2,3 and
    // each beat shows up one cycle after its grant.
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      if (c == 0) begin
        check("rr_empty", 32'(out_valid), 32'h0);
      end else begin
        check("rr_valid", 32'(out_valid), 32'h1);
        check("rr_id",    32'(out_id),    32'((c - 1) % 4));
        check("rr_data",  32'(out_data),  32'(8'h10 + 8'((c - 1) % 4)));
      end
    end

    // Backpressure: only requester 2 is valid (0xA5). ptr is 0, so 2 wins.
    @(negedge clk);
    req_valid = 4'b0100;
    beat[2]   = 8'hA5;
    #1;
    check("bp_prev_id", 32'(out_id),    32'h3);
    check("bp_ready2",  32'(req_ready), 32'b0100);

    @(negedge clk);
    out_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    check("bp_valid", 32'(out_valid), 32'h1);
    check("bp_data",  32'(out_data),  32'hA5);
    check("bp_id",    32'(out_id),    32'h2);
    check("bp_ready", 32'(req_ready), 32'h0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("bp_hold_data",  32'(out_data),  32'hA5);
      check("bp_hold_id",    32'(out_id),    32'h2);
      check("bp_hold_ready", 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_next_winner", 32'(req_ready), 32'b1000);

    // Requester 1 alone, which moves ptr to 2.
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    check("bp_after_id",   32'(out_id),    32'h3);
    check("bp_after_data", 32'(out_data),  32'h13);
    check("ptr2_ready",    32'(req_ready), 32'b0010);

    // Sparse: only requesters 1 and 3, with ptr=2, so grants go 3,1,3,1.
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    check("sparse_first_id", 32'(out_id), 32'h1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
        check("sparse_id", 32'(out_id), (k % 2) ? 32'h3 : 32'h1);
      end
      check("sparse_ready", 32'(req_ready), (k % 2) ? 32'b0010 : 32'b1000);
    end

    // Idle: nothing valid. The stage drains, data holds, and ptr stays at 2.
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    check("idle_last_id", 32'(out_id),    32'h1);
    check("idle_ready",   32'(req_ready), 32'h0);
    @(negedge clk);
    #1;
    check("idle_drained", 32'(out_valid), 32'h0);
    check("idle_data",    32'(out_data),  32'h11);
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    check("idle_ptr_hold", 32'(req_ready), 32'b0100);

    // Reset while a beat is held: it is dropped at once and ptr returns to 0.
    @(negedge clk);
    #1;
    check("mid_valid", 32'(out_valid), 32'h1);
    check("mid_data",  32'(out_data),  32'hA5);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data",  32'(out_data),  32'h00);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_ptr", 32'(req_ready), 32'b0001);

`ifdef SHARED_REG_ARB_LOCK_EN
    // Lock cap: requester 0 holds its lock with everyone valid. Exactly 16
    // beats come from 0, then requester 1 wins.
    req_lock = 4'b0001;
    #1;
    for (int c = 0; c <= DEPTH; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
        check("cap_id", 32'(out_id), 32'h0);
      end
      check("cap_ready", 32'(req_ready), (c < DEPTH) ? 32'b0001 : 32'b0010);
    end
    req_lock = 4'b0100;

    // Early unlock: requester 2 locks, sends 3 beats, then drops the lock on
    // its 4th beat. Requester 3 wins next.
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b == 3) req_lock = 4'b0000;
      #1;
      check("unlock_id",    32'(out_id),    (b == 0) ? 32'h1 : 32'h2);
      check("unlock_ready", 32'(req_ready), 32'b0100);
    end
    @(negedge clk);
    req_lock = 4'b1000;
    #1;
    check("unlock_last_id", 32'(out_id),    32'h2);
    check("unlock_next",    32'(req_ready), 32'b1000);

    // Abandon: requester 3 locks, then drops its valid. No one is granted
    // that cycle. The next cycle, round robin resumes at 0.
    @(negedge clk);
    req_valid = 4'b0111;
    req_lock  = 4'b0000;
    #1;
    check("abandon_id",    32'(out_id),    32'h3);
    check("abandon_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    #1;
    check("abandon_released", 32'(req_ready), 32'b0001);
    check("abandon_drained",  32'(out_valid), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
